// File: rtl/axis_window_pkg.sv
// Shared types and helpers for the multi-channel streaming KxK window receiver.
package axis_window_pkg;

  // Default geometry; the top module exposes these as overridable parameters.
  localparam int unsigned DATA_WIDTH_DEF  = 8;
  localparam int unsigned CHANNELS_DEF    = 1;
  localparam int unsigned KERNEL_SIZE_DEF = 5;
  localparam int unsigned MAX_WIDTH_DEF   = 1024;
  localparam int unsigned DIM_WIDTH_DEF   = 12;

  // Derived widths for the default geometry.
  localparam int unsigned PIX_W_DEF  = CHANNELS_DEF * DATA_WIDTH_DEF;
  localparam int unsigned WIN_W_DEF  = PIX_W_DEF * KERNEL_SIZE_DEF * KERNEL_SIZE_DEF;
  localparam int unsigned ADDR_W_DEF = $clog2(MAX_WIDTH_DEF);

  // Frame tracking: waiting for a valid SOF, or walking a frame.
  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } state_t;

  // Element index of (channel, row, column) inside the flattened window bus.
  function automatic int unsigned win_idx(input int unsigned ch, input int unsigned r,
                                          input int unsigned c, input int unsigned k);
    return (ch * k + r) * k + c;
  endfunction

endpackage

// File: rtl/axis_window_receiver_mc_line_buffer.sv
// One line of pixel history: combinational read, synchronous write. Contents are not reset.
module window_line_buffer
  import axis_window_pkg::*;
#(
  parameter int unsigned PIX_W  = PIX_W_DEF,
  parameter int unsigned DEPTH  = MAX_WIDTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [PIX_W-1:0]  wdata,
  output logic [PIX_W-1:0]  rd_data_c
);

  logic [PIX_W-1:0] mem [DEPTH];

  // Read-before-write: the read port sees the old value during the write cycle.
  assign rd_data_c = mem[addr];

  // Store the incoming column sample.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/axis_window_receiver_mc.sv
// AXI-Stream KxK neighbourhood generator with K-1 line buffers, per-channel packing,
// single-stage output register with backpressure, frame/line markers and error pulses.
module axis_window_receiver_mc
  import axis_window_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned CHANNELS    = CHANNELS_DEF,
  parameter int unsigned KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int unsigned MAX_WIDTH   = MAX_WIDTH_DEF,
  parameter int unsigned DIM_WIDTH   = DIM_WIDTH_DEF
) (
  input  logic                                                 clk,
  input  logic                                                 aresetn,
  input  logic [DIM_WIDTH-1:0]                                 i_image_width,
  input  logic [CHANNELS*DATA_WIDTH-1:0]                       s_tdata,
  input  logic                                                 s_tvalid,
  output logic                                                 s_tready,
  input  logic                                                 s_tuser,
  input  logic                                                 s_tlast,
  output logic [CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] m_window,
  output logic                                                 m_tvalid,
  input  logic                                                 m_tready,
  output logic                                                 m_tuser,
  output logic                                                 m_tlast,
  output logic                                                 o_cfg_error,
  output logic                                                 o_eol_error,
  output logic                                                 o_sof_error
);

  localparam int unsigned K      = KERNEL_SIZE;
  localparam int unsigned PIX_W  = CHANNELS * DATA_WIDTH;
  localparam int unsigned WIN_W  = PIX_W * K * K;
  localparam int unsigned ADDR_W = $clog2(MAX_WIDTH);
  localparam int unsigned ROW_W  = $clog2(K);

  // Registered state
  state_t                            state_q, state_d;
  logic [DIM_WIDTH-1:0]              width_q, width_d;
  logic [DIM_WIDTH-1:0]              col_q, col_d;
  logic [ROW_W-1:0]                  row_q, row_d;
  logic [K-1:0][K-1:0][PIX_W-1:0]    win_q, win_d;
  logic                              first_q, first_d;
  logic                              m_tvalid_q, m_tvalid_d;
  logic                              m_tuser_q, m_tuser_d;
  logic                              m_tlast_q, m_tlast_d;
  logic                              cfg_err_q, cfg_err_d;
  logic                              eol_err_q, eol_err_d;
  logic                              sof_err_q, sof_err_d;

  // Beat decode
  logic                              accept_c;
  logic                              sof_c;
  logic                              cfg_ok_c;
  logic                              beat_c;
  logic [DIM_WIDTH-1:0]              col_eff_c;
  logic [ROW_W-1:0]                  row_eff_c;
  logic [DIM_WIDTH-1:0]              w_eff_c;
  logic [ADDR_W-1:0]                 addr_c;
  logic                              line_end_c;
  logic                              fire_c;
  logic [PIX_W-1:0]                  lb_rd_c [K-1];

  // Single output register stage: take a new beat whenever the output slot is free or draining.
  assign s_tready = ~m_tvalid_q | m_tready;

  // Classify the accepted beat; an SOF beat is processed as (row 0, col 0) of the new frame.
  always_comb begin
    accept_c  = s_tvalid & s_tready;
    sof_c     = accept_c & s_tuser;
    cfg_ok_c  = (32'(i_image_width) >= K) && (32'(i_image_width) <= MAX_WIDTH);
    beat_c    = 1'b0;
    col_eff_c = col_q;
    row_eff_c = row_q;
    w_eff_c   = width_q;
    if (sof_c) begin
      if (cfg_ok_c) begin
        beat_c    = 1'b1;
        col_eff_c = '0;
        row_eff_c = '0;
        w_eff_c   = i_image_width;
      end
    end else if (accept_c && (state_q == RUN)) begin
      beat_c = 1'b1;
    end
    addr_c     = ADDR_W'(col_eff_c);
    line_end_c = (col_eff_c == (w_eff_c - DIM_WIDTH'(1)));
    fire_c     = beat_c && (row_eff_c == ROW_W'(K - 1)) && (32'(col_eff_c) >= (K - 1));
  end

  // Line buffer chain: line 0 takes the input, line g takes line g-1's previous value.
  for (genvar g = 0; g < int'(K) - 1; g++) begin : g_lb
    logic [PIX_W-1:0] wdata_c;
    if (g == 0) begin : g_first
      assign wdata_c = s_tdata;
    end else begin : g_next
      assign wdata_c = lb_rd_c[g-1];
    end
    window_line_buffer #(
      .PIX_W (PIX_W),
      .DEPTH (MAX_WIDTH),
      .ADDR_W(ADDR_W)
    ) u_lb (
      .clk      (clk),
      .we       (beat_c),
      .addr     (addr_c),
      .wdata    (wdata_c),
      .rd_data_c(lb_rd_c[g])
    );
  end

  // Next-state: frame FSM, counters, window shift, output register and error pulses.
  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    col_d      = col_q;
    row_d      = row_q;
    win_d      = win_q;
    first_d    = first_q;
    m_tvalid_d = m_tvalid_q & ~m_tready;
    m_tuser_d  = m_tuser_q;
    m_tlast_d  = m_tlast_q;
    cfg_err_d  = 1'b0;
    eol_err_d  = 1'b0;
    sof_err_d  = 1'b0;

    case (state_q)
      WAIT_SOF: begin
        if (sof_c) begin
          width_d = i_image_width;
          if (cfg_ok_c) begin
            state_d = RUN;
            first_d = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (sof_c) begin
          width_d   = i_image_width;
          sof_err_d = (col_q != '0) || (row_q != '0);
          if (cfg_ok_c) begin
            first_d = 1'b1;
          end else begin
            state_d   = WAIT_SOF;
            cfg_err_d = 1'b1;
          end
        end
      end
      default: state_d = WAIT_SOF;
    endcase

    if (beat_c) begin
      eol_err_d = s_tlast ^ line_end_c;
      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(K) - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      for (int r = 0; r < int'(K) - 1; r++) begin
        win_d[r][K-1] = lb_rd_c[int'(K) - 2 - r];
      end
      win_d[K-1][K-1] = s_tdata;
      if (line_end_c) begin
        col_d = '0;
        row_d = (row_eff_c == ROW_W'(K - 1)) ? row_eff_c : row_eff_c + ROW_W'(1);
      end else begin
        col_d = col_eff_c + DIM_WIDTH'(1);
        row_d = row_eff_c;
      end
    end

    if (fire_c) begin
      m_tvalid_d = 1'b1;
      m_tuser_d  = first_q;
      m_tlast_d  = line_end_c;
      first_d    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= WAIT_SOF;
      width_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      win_q      <= '0;
      first_q    <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tuser_q  <= 1'b0;
      m_tlast_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
      eol_err_q  <= 1'b0;
      sof_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      col_q      <= col_d;
      row_q      <= row_d;
      win_q      <= win_d;
      first_q    <= first_d;
      m_tvalid_q <= m_tvalid_d;
      m_tuser_q  <= m_tuser_d;
      m_tlast_q  <= m_tlast_d;
      cfg_err_q  <= cfg_err_d;
      eol_err_q  <= eol_err_d;
      sof_err_q  <= sof_err_d;
    end
  end

  // Repack the window register into channel-major order on the output bus.
  always_comb begin
    m_window = '0;
    for (int ch = 0; ch < int'(CHANNELS); ch++) begin
      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(K); c++) begin
          m_window[win_idx(ch, r, c, K)*DATA_WIDTH +: DATA_WIDTH] =
            win_q[r][c][ch*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign m_tvalid    = m_tvalid_q;
  assign m_tuser     = m_tuser_q;
  assign m_tlast     = m_tlast_q;
  assign o_cfg_error = cfg_err_q;
  assign o_eol_error = eol_err_q;
  assign o_sof_error = sof_err_q;

endmodule

// File: doc/axis_window_receiver_mc.md
Name: axis_window_receiver_mc

Overview:
Multi-channel, backpressure-aware successor to the streaming KxK window receiver. It takes an AXI-Stream pixel stream with SOF on tuser and EOL on tlast, buffers K-1 lines, and emits a full KxK neighbourhood per channel for every pixel whose window lies fully inside the frame ("valid-only" windows). It feeds the median/convolution kernels and adds tready handshaking, channel packing, line/frame markers and error flags.

Parameters:
DATA_WIDTH, 8, bits per channel sample
CHANNELS, 1, samples packed per pixel (e.g. 3 for RGB)
KERNEL_SIZE, 5, window edge K; odd, 3..7
MAX_WIDTH, 1024, line buffer depth in pixels
DIM_WIDTH, 12, width of i_image_width

Ports:
clk  in  1  clock
aresetn  in  1  asynchronous active-low reset
i_image_width  in  DIM_WIDTH  active pixels per line; sampled only on an accepted SOF beat
s_tdata  in  CHANNELS*DATA_WIDTH  pixel; channel ch at [ch*DATA_WIDTH +: DATA_WIDTH]
s_tvalid  in  1  input valid
s_tready  out  1  input ready
s_tuser  in  1  start of frame
s_tlast  in  1  end of line
m_window  out  CHANNELS*K*K*DATA_WIDTH  element (ch,r,c) at (((ch*K+r)*K+c)*DATA_WIDTH); r=0 oldest row, c=0 leftmost column
m_tvalid  out  1  window valid
m_tready  in  1  downstream ready
m_tuser  out  1  first window of frame
m_tlast  out  1  last window of output line
o_cfg_error  out  1  one-cycle pulse: SOF with width < K or > MAX_WIDTH
o_eol_error  out  1  one-cycle pulse: tlast disagrees with column count
o_sof_error  out  1  one-cycle pulse: SOF accepted while col != 0 or mid-frame

Behaviour:
- Reset: all outputs 0 (m_tvalid, m_tuser, m_tlast, error pulses, m_window); col=0, row=0, window registers 0, FSM=WAIT_SOF. Line buffer RAM contents are not reset.
- Handshake: accept = s_tvalid & s_tready. s_tready = ~m_tvalid | m_tready (single output register stage). All state advances only on accept. The output holds stable while m_tvalid & ~m_tready.
- FSM WAIT_SOF: s_tready follows the rule above. Non-SOF beats are dropped. An SOF beat latches width W. If K <= W <= MAX_WIDTH: go to RUN and process the beat as (row 0, col 0). Otherwise pulse o_cfg_error, drop the beat, stay in WAIT_SOF.
- FSM RUN, per accepted beat:
  - Read column col from the K-1 line buffers (combinational read, read-before-write).
  - Line 0 is written with the input; line k is written with the old line k-1 value.
  - The window shifts left one column. The new right column is {lb[K-2],...,lb[0],input}, top to bottom.
  - col increments; at col==W-1 it wraps to 0 and row increments, saturating at K-1.
- EOL check: s_tlast must equal (col==W-1). On mismatch, pulse o_eol_error. The column wraps on the count; tlast does not affect it.
- SOF in RUN: if col!=0 or row!=0, pulse o_sof_error. Relatch W (same cfg check as WAIT_SOF), restart at row 0, col 0. Previous line buffer data is ignored via the row counter.
- Output: m_tvalid is set the cycle after an accept where row==K-1 and col>=K-1 (pre-increment values). Output frame is (W-K+1) x (H-K+1); latency 1 cycle.
- Output markers:
  - m_tuser=1 on the first window after each SOF.
  - m_tlast=1 when the window's input col==W-1.
- m_tvalid clears on (m_tready & no new window).
- Error pulses are independent of backpressure and last one cycle.
- Simultaneous SOF and EOL on a W=1 beat cannot occur, because W>=K is enforced.

Decomposition:
- Package axis_window_pkg:
  - localparams for derived widths (PIX_W=CHANNELS*DATA_WIDTH, WIN_W, ADDR_W=$clog2(MAX_WIDTH)).
  - FSM enum state_t {WAIT_SOF, RUN}.
  - Function win_idx(ch,r,c).
- Sub-module window_line_buffer:
  - One PIX_W x MAX_WIDTH RAM with combinational read and synchronous write-enable.
  - Instantiated K-1 times via generate.

Test Plan:
1. CHANNELS=1, K=5, W=8, 8 lines of ramp 0..63, m_tready=1 -> 16 windows, 4 with m_tlast. The first appears 1 cycle after pixel 36 with window[r][c]=r*8+c (top-left 0, centre 18, bottom-right 36). m_tuser only on the first.
2. Same stream, m_tready toggled 1010.. and s_tvalid randomly gapped -> identical 16 windows in order. m_window is stable whenever m_tvalid & ~m_tready; no beat is lost.
3. CHANNELS=3, channel ch = ramp + ch*64 -> channel slice ch of every window equals the channel-0 window + ch*64.
4. SOF with i_image_width=3 (<K) -> o_cfg_error pulse, no windows, stays in WAIT_SOF. Then SOF with W=8 -> normal output as in test 1.
5. Correct W=8 frame but tlast asserted at col 5 of line 2 -> one o_eol_error pulse; window contents still follow the W=8 count. A second SOF at col 3 -> o_sof_error pulse and counters restart at 0.
6. aresetn low mid-frame while m_tvalid=1 -> all outputs 0 immediately. After release, beats are dropped until SOF, then behaviour is identical to test 1.
